fir_serial_sym: RTL and testbench

FIR_SERIAL_SYM -- requirements
Module: fir_serial_sym

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_mac.sv | 53 +++++
 rtl/fir_serial_sym.sv | 193 +++++++++++++++++++
 tb/tb_fir_serial_sym.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the serial symmetric FIR filter.
//   fir_state_e : sequencer states (IDLE, ACCUM, ROUND, DONE)
//   frac_bits   : fractional bits of a Q1.(CW-1) coefficient
//   acc_width   : accumulator width that cannot overflow for a given filter
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fir_state_e;

  function automatic int frac_bits(input int cw);
    return cw - 1;
  endfunction

  // Pre-add sum (dw+1 bits) times coefficient (cw bits), summed over
  // (ntaps+1)/2 terms.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + 1 + cw + $clog2((ntaps + 1) / 2);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Pre-add / multiply / accumulate datapath for the symmetric FIR.
//   clk, reset : clock, asynchronous active-high reset (clears acc)
//   clr        : load the accumulator with zero (has priority over en)
//   en         : acc += coef * (xa + xb)
//   xa, xb     : unsigned samples forming the symmetric pair
//   coef       : signed coefficient
//   acc        : signed accumulator value
module fir_mac #(
  parameter int DW   = 10,
  parameter int CW   = 16,
  parameter int ACCW = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [DW-1:0]   xa,
  input  logic [DW-1:0]   xb,
  input  logic [CW-1:0]   coef,
  output logic [ACCW-1:0] acc
);

  localparam int PW = CW + DW + 2;

  logic [DW:0]             pre_sum;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc_q;
  logic signed [ACCW-1:0]  acc_d;

  assign pre_sum = {1'b0, xa} + {1'b0, xb};
  // Pre-add sum is unsigned: zero-extend before the signed multiply.
  assign prod    = PW'($signed(coef)) * PW'($signed({1'b0, pre_sum}));

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACCW'(prod);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_serial_sym.sv
// Serial symmetric FIR filter: one pre-added tap pair per clock.
//   clk, reset          : clock, asynchronous active-high reset
//   in_data/valid/ready : unsigned sample input handshake
//   out_data/valid/ready: unsigned filtered output handshake
//   coef_wr/addr/data   : coefficient write port, accepted only in IDLE
//   coef_err            : one-cycle pulse when a coefficient write is rejected
// Build option: define FIR_SATURATE_EN to clamp the rounded result to
// [0, 2^DW-1]; otherwise the low DW bits are kept (wrap).
// coef_addr carries clog2(M+1) bits so indices at or above M are
// representable and can be rejected.
module fir_serial_sym
  import fir_pkg::*;
#(
  parameter  int NTAPS = 31,
  parameter  int DW    = 10,
  parameter  int CW    = 16,
  localparam int AW    = $clog2((NTAPS + 1) / 2 + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          coef_wr,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          coef_err
);

  localparam int M    = (NTAPS + 1) / 2;
  localparam int KW   = $clog2(M);
  localparam int XIW  = $clog2(NTAPS);
  localparam int ACCW = acc_width(DW, CW, NTAPS);
  localparam int FRAC = frac_bits(CW);
  localparam logic signed [ACCW-1:0] HALF = ACCW'(64'd1 << (CW - 2));

  fir_state_e             state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [DW-1:0]          x_q [NTAPS];
  logic [DW-1:0]          x_d [NTAPS];
  logic [CW-1:0]          c_q [M];
  logic [CW-1:0]          c_d [M];
  logic [DW-1:0]          out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   coef_err_q, coef_err_d;
  logic                   pend_q, pend_d;
  logic [KW-1:0]          pend_addr_q, pend_addr_d;
  logic [CW-1:0]          pend_data_q, pend_data_d;

  logic                   take;
  logic                   last_tap;
  logic                   addr_ok;
  logic [XIW-1:0]         idx_a, idx_b;
  logic [DW-1:0]          mac_xa, mac_xb;
  logic [ACCW-1:0]        acc;
  logic signed [ACCW-1:0] acc_s;
  logic [DW-1:0]          rounded;

  assign take     = in_valid && (state_q == IDLE);
  assign last_tap = (k_q == KW'(M - 1));
  assign addr_ok  = (coef_addr < AW'(M));
  assign idx_a    = XIW'(k_q);
  assign idx_b    = XIW'(NTAPS - 1) - XIW'(k_q);
  assign mac_xa   = x_q[idx_a];
  // Centre tap has no mirror partner.
  assign mac_xb   = last_tap ? '0 : x_q[idx_b];
  assign acc_s    = $signed(acc);

`ifdef FIR_SATURATE_EN
  logic signed [ACCW-1:0] r_full;
  localparam logic signed [ACCW-1:0] OUT_MAX = ACCW'((64'd1 << DW) - 1);
  assign r_full  = (acc_s + HALF) >>> FRAC;
  assign rounded = r_full[ACCW-1]   ? '0 :
                   (r_full > OUT_MAX) ? '1 : r_full[DW-1:0];
`else
  assign rounded = DW'((acc_s + HALF) >>> FRAC);
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    x_d         = x_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    coef_err_d  = 1'b0;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;

    // A write coinciding with a sample handshake is parked and committed
    // in ROUND, so the sample being accumulated sees the old coefficients.
    if (coef_wr) begin
      if ((state_q == IDLE) && addr_ok) begin
        if (take) begin
          pend_d      = 1'b1;
          pend_addr_d = coef_addr[KW-1:0];
          pend_data_d = coef_data;
        end else begin
          c_d[coef_addr[KW-1:0]] = coef_data;
        end
      end else begin
        coef_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (take) begin
          for (int unsigned i = 1; i < NTAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0]  = in_data;
          k_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (last_tap) begin
          state_d = ROUND;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ROUND: begin
        out_data_d  = rounded;
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (pend_q) begin
          c_d[pend_addr_q] = pend_data_q;
          pend_d           = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x_q         <= '{default: '0};
      c_q         <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      coef_err_q  <= coef_err_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  fir_mac #(
    .DW  (DW),
    .CW  (CW),
    .ACCW(ACCW)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (take),
    .en   (state_q == ACCUM),
    .xa   (mac_xa),
    .xb   (mac_xb),
    .coef (c_q[k_q]),
    .acc  (acc)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_serial_sym.sv
module tb_fir_serial_sym;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        coef_wr;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_err;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [9:0] din;
    logic [9:0] dout;
  } vec_t;

  vec_t imp_tbl [32];
  vec_t dc_tbl  [20];

`ifdef FIR_SATURATE_EN
  localparam logic [9:0] SAT_POS = 10'd1023;
  localparam logic [9:0] SAT_NEG = 10'd0;
`else
  localparam logic [9:0] SAT_POS = 10'd992;
  localparam logic [9:0] SAT_NEG = 10'd1;
`endif

  fir_serial_sym #(.NTAPS(31), .DW(10), .CW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .coef_wr  (coef_wr),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .coef_err (coef_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [4:0] a, input logic [15:0] d);
    coef_wr = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_wr = 1'b0;
  endtask

  // Waits for out_valid; cyc is the cycle index relative to the handshake cycle.
  task automatic wait_result(input string nm, input int start_cyc, output logic [9:0] y);
    int cyc = start_cyc;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check({nm, " latency"}, cyc, 18);
    y = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_sample(input string nm, input logic [9:0] d, output logic [9:0] y);
    int w = 0;
    while (!in_ready && w < 60) begin
      tick();
      w++;
    end
    if (!in_ready) check({nm, " in_ready wait"}, 0, 1);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    wait_result(nm, 1, y);
  endtask

  initial begin
    logic [9:0] y;
    int cnt;

    reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0;

    for (int i = 0; i < 32; i++) imp_tbl[i] = '{10'd0, 10'd0};
    imp_tbl[0]  = '{10'd1000, 10'd500};
    imp_tbl[30] = '{10'd0,    10'd500};
    for (int i = 0; i < 20; i++) dc_tbl[i] = '{10'd800, (i < 15) ? 10'd0 : 10'd400};

    // Reset state
    tick(); tick();
    check("rst in_ready",  in_ready,  1);
    check("rst out_valid", out_valid, 0);
    check("rst coef_err",  coef_err,  0);
    check("rst out_data",  out_data,  0);
    reset = 1'b0;
    tick();

    // Impulse
    write_coef(5'd0, 16'h4000);
    for (int i = 0; i < 32; i++) begin
      run_sample("impulse", imp_tbl[i].din, y);
      check("impulse out", y, imp_tbl[i].dout);
    end

    // DC through centre tap
    write_coef(5'd0, 16'h0000);
    write_coef(5'd15, 16'h4000);
    for (int i = 0; i < 20; i++) begin
      run_sample("dc", dc_tbl[i].din, y);
      check("dc out", y, dc_tbl[i].dout);
    end

    // Saturation / wrap, positive then negative
    for (int i = 0; i < 16; i++) write_coef(5'(i), 16'h7FFF);
    for (int i = 0; i < 31; i++) run_sample("satpos", 10'd1023, y);
    check("satpos out", y, SAT_POS);
    for (int i = 0; i < 15; i++) write_coef(5'(i), 16'h0000);
    write_coef(5'd15, 16'h8000);
    run_sample("satneg", 10'd1023, y);
    check("satneg out", y, SAT_NEG);

    // Output back-pressure: DONE holds, in_valid ignored
    write_coef(5'd15, 16'h0000);
    write_coef(5'd0, 16'h4000);
    in_valid = 1'b1; in_data = 10'd200;
    tick();
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 60) begin
      tick();
      cnt++;
    end
    check("hold latency", cnt, 18);
    in_valid = 1'b1; in_data = 10'd7;
    for (int i = 0; i < 10; i++) begin
      check("hold out_data",  out_data,  612);
      check("hold out_valid", out_valid, 1);
      check("hold in_ready",  in_ready,  0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post in_ready",  in_ready,  1);
    check("post out_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("accept in_ready", in_ready, 0);
    wait_result("after hold", 1, y);
    check("after hold out", y, 515);

    // Coefficient write during ACCUM is rejected
    in_valid = 1'b1; in_data = 10'd100;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    coef_wr = 1'b1; coef_addr = 5'd0; coef_data = 16'h7FFF;
    tick();
    coef_wr = 1'b0;
    check("accum coef_err pulse", coef_err, 1);
    tick();
    check("accum coef_err clear", coef_err, 0);
    wait_result("accum wr", 5, y);
    check("accum wr out", y, 562);

    // Write concurrent with handshake: old set used, new set next sample
    coef_wr = 1'b1; coef_addr = 5'd0; coef_data = 16'h2000;
    in_valid = 1'b1; in_data = 10'd400;
    tick();
    coef_wr = 1'b0; in_valid = 1'b0;
    check("concurrent coef_err", coef_err, 0);
    wait_result("concurrent", 1, y);
    check("concurrent out old", y, 712);
    run_sample("newcoef", 10'd0, y);
    check("newcoef out", y, 256);

    // Out-of-range address
    write_coef(5'd16, 16'h7FFF);
    check("addr16 coef_err", coef_err, 1);
    tick();
    check("addr16 coef_err clear", coef_err, 0);
    run_sample("addr16", 10'd0, y);
    check("addr16 out", y, 256);

    // Reset in ACCUM at k=7
    in_valid = 1'b1; in_data = 10'd5;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort in_ready",  in_ready,  1);
    tick(); tick();
    reset = 1'b0;
    cnt = 0;
    repeat (25) begin
      tick();
      if (out_valid) cnt++;
    end
    check("abort no out_valid", cnt, 0);
    check("abort out_data", out_data, 0);
    run_sample("post-reset impulse", 10'd1000, y);
    check("post-reset impulse out", y, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
